// File: rtl/sensor_nivel_filtro_pkg.sv
// Purpose : shared types, thermometer patterns and mapping helpers for the tank level filter.
// Latency : n/a (types and pure functions only).
// Backpressure: none.
// Contents: nivel_t level encoding, state_t FSM states, PAT_* (A,M,B) patterns,
//           pattern validity / pattern<->level mapping functions.
package nivel_pkg;

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        BAIXO = 2'd1,
        MEDIO = 2'd2,
        ALTO  = 2'd3
    } nivel_t;

    // Level states share their low two bits with nivel_t so the mapping is a plain slice.
    typedef enum logic [2:0] {
        ST_VAZIO = 3'd0,
        ST_BAIXO = 3'd1,
        ST_MEDIO = 3'd2,
        ST_ALTO  = 3'd3,
        ST_ERRO  = 3'd4
    } state_t;

    // Patterns are ordered {A, M, B}.
    localparam logic [2:0] PAT_VAZIO = 3'b000;
    localparam logic [2:0] PAT_BAIXO = 3'b001;
    localparam logic [2:0] PAT_MEDIO = 3'b011;
    localparam logic [2:0] PAT_ALTO  = 3'b111;

    function automatic logic pat_is_valid(input logic [2:0] pat);
        return (pat == PAT_VAZIO) || (pat == PAT_BAIXO) ||
               (pat == PAT_MEDIO) || (pat == PAT_ALTO);
    endfunction

    function automatic nivel_t pat_to_nivel(input logic [2:0] pat);
        nivel_t n;
        case (pat)
            PAT_BAIXO: n = BAIXO;
            PAT_MEDIO: n = MEDIO;
            PAT_ALTO:  n = ALTO;
            default:   n = VAZIO;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] nivel_to_pat(input nivel_t n);
        logic [2:0] p;
        case (n)
            BAIXO:   p = PAT_BAIXO;
            MEDIO:   p = PAT_MEDIO;
            ALTO:    p = PAT_ALTO;
            default: p = PAT_VAZIO;
        endcase
        return p;
    endfunction

    function automatic state_t nivel_to_state(input nivel_t n);
        return state_t'({1'b0, n});
    endfunction

endpackage

// File: rtl/sensor_nivel_filtro_debounce_bit.sv
// Purpose : 2-flop synchronizer plus mismatch counter that debounces one float switch.
// Latency : raw change held stable -> deb toggles DEBOUNCE_CYCLES+2 clocks later.
// Backpressure: none; free-running sampler.
// Ports   : clk, rst_n (sync, active-low), raw (async switch in), deb (debounced bit out).
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the new value.
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_nivel_filtro.sv
// Purpose : debounce three tank float switches, check thermometer consistency, report level/fault.
// Latency : raw edge held stable -> A/M/B/nivel change after 2 + DEBOUNCE_CYCLES + 1 clocks.
// Backpressure: none; outputs are level signals plus a one-cycle nivel_valid strobe.
// Ports   : clk, rst_n (sync, active-low), sa_raw/sm_raw/sb_raw (async switches),
//           A/M/B (filtered level bits), nivel (encoded level), nivel_valid (change strobe),
//           erro (sensor fault). Build option: ERRO_STICKY_EN makes the fault state exit only by reset.
module sensor_nivel_filtro
    import nivel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int ERR_PERSIST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sa_raw,
    input  logic       sm_raw,
    input  logic       sb_raw,
    output logic       A,
    output logic       M,
    output logic       B,
    output logic [1:0] nivel,
    output logic       nivel_valid,
    output logic       erro
);

    // err_cnt counts invalid cycles in a level state and stable valid cycles in ERRO.
    localparam int ERR_MAX = (ERR_PERSIST_CYCLES > DEBOUNCE_CYCLES) ? ERR_PERSIST_CYCLES
                                                                   : DEBOUNCE_CYCLES;
    localparam int ERR_W = $clog2(ERR_MAX + 1);
    localparam logic [ERR_W-1:0] EP_LAST = ERR_W'(ERR_PERSIST_CYCLES - 1);

    logic a_deb, m_deb, b_deb;
    logic [2:0] pat;
    logic       pat_ok;

    state_t           state, state_d;
    logic [ERR_W-1:0] err_cnt, err_cnt_d;
    nivel_t           nivel_q, nivel_d;
    logic             erro_d;

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .raw(sa_raw), .deb(a_deb));
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_m (
        .clk(clk), .rst_n(rst_n), .raw(sm_raw), .deb(m_deb));
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .rst_n(rst_n), .raw(sb_raw), .deb(b_deb));

    assign pat    = {a_deb, m_deb, b_deb};
    assign pat_ok = pat_is_valid(pat);

`ifndef ERRO_STICKY_EN
    localparam logic [ERR_W-1:0] DC_LAST = ERR_W'(DEBOUNCE_CYCLES - 1);

    // Previous cycle's pattern, so recovery from ERRO needs the same valid pattern held.
    logic [2:0] pat_q;
    logic       run_cont;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q <= PAT_VAZIO;
        end else begin
            pat_q <= pat;
        end
    end

    assign run_cont = (err_cnt != '0) && (pat == pat_q);
`endif

    // State register, error counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_VAZIO;
            err_cnt     <= '0;
            nivel_q     <= VAZIO;
            nivel_valid <= 1'b0;
            erro        <= 1'b0;
            {A, M, B}   <= PAT_VAZIO;
        end else begin
            state       <= state_d;
            err_cnt     <= err_cnt_d;
            nivel_q     <= nivel_d;
            nivel_valid <= (nivel_d != nivel_q);
            erro        <= erro_d;
            {A, M, B}   <= nivel_to_pat(nivel_d);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state;
        err_cnt_d = err_cnt;
        case (state)
            ST_ERRO: begin
`ifdef ERRO_STICKY_EN
                state_d   = ST_ERRO;
                err_cnt_d = '0;
`else
                if (!pat_ok) begin
                    err_cnt_d = '0;
                end else if (!run_cont) begin
                    // First cycle of a new valid run.
                    err_cnt_d = ERR_W'(1);
                end else if (err_cnt == DC_LAST) begin
                    state_d   = nivel_to_state(pat_to_nivel(pat));
                    err_cnt_d = '0;
                end else begin
                    err_cnt_d = err_cnt + ERR_W'(1);
                end
`endif
            end
            default: begin
                if (pat_ok) begin
                    state_d   = nivel_to_state(pat_to_nivel(pat));
                    err_cnt_d = '0;
                end else if (err_cnt >= EP_LAST) begin
                    state_d   = ST_ERRO;
                    err_cnt_d = '0;
                end else begin
                    err_cnt_d = err_cnt + ERR_W'(1);
                end
            end
        endcase
    end

    // Output logic: level outputs follow level states and freeze while in ERRO.
    always_comb begin
        nivel_d = nivel_q;
        erro_d  = 1'b0;
        if (state_d == ST_ERRO) begin
            erro_d = 1'b1;
        end else begin
            nivel_d = nivel_t'(state_d[1:0]);
        end
    end

    assign nivel = nivel_q;

endmodule

// File: tb/tb_sensor_nivel_filtro.sv
// Purpose : directed self-checking bench for sensor_nivel_filtro (DEBOUNCE_CYCLES=4, ERR_PERSIST_CYCLES=3).
// Latency : n/a.
// Backpressure: n/a.
module tb_sensor_nivel_filtro;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sa_raw, sm_raw, sb_raw;
    logic       A, M, B;
    logic [1:0] nivel;
    logic       nivel_valid;
    logic       erro;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sensor_nivel_filtro #(
        .DEBOUNCE_CYCLES   (4),
        .ERR_PERSIST_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sa_raw     (sa_raw),
        .sm_raw     (sm_raw),
        .sb_raw     (sb_raw),
        .A          (A),
        .M          (M),
        .B          (B),
        .nivel      (nivel),
        .nivel_valid(nivel_valid),
        .erro       (erro)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for sampling and driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sa_raw = 1'b0;
        sm_raw = 1'b0;
        sb_raw = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // 1: reset with all switches high keeps outputs cleared.
        rst_n  = 1'b0;
        sa_raw = 1'b1;
        sm_raw = 1'b1;
        sb_raw = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("rst_amb",   {A, M, B}, 3'b000);
            chk("rst_nivel", nivel, 2'd0);
            chk("rst_erro",  erro, 1'b0);
            chk("rst_vld",   nivel_valid, 1'b0);
        end

        // 2: sb rises from VAZIO; output appears 7 clocks later with a single strobe.
        do_reset();
        step(4);
        chk("t2_idle_nivel", nivel, 2'd0);
        sb_raw = 1'b1;
        step(6);
        chk("t2_early_nivel", nivel, 2'd0);
        chk("t2_early_vld",   nivel_valid, 1'b0);
        step(1);
        chk("t2_amb",   {A, M, B}, 3'b001);
        chk("t2_nivel", nivel, 2'd1);
        chk("t2_vld",   nivel_valid, 1'b1);
        step(1);
        chk("t2_vld_off", nivel_valid, 1'b0);
        chk("t2_hold",    nivel, 2'd1);

        // 3: 3-cycle glitch on sb is shorter than the debounce window.
        do_reset();
        sb_raw = 1'b1;
        step(3);
        sb_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("t3_vld",   nivel_valid, 1'b0);
            chk("t3_nivel", nivel, 2'd0);
            step(1);
        end

        // 4: MEDIO, then inconsistent 101 held -> ERRO while outputs keep 011.
        do_reset();
        sm_raw = 1'b1;
        sb_raw = 1'b1;
        step(12);
        chk("t4_medio_nivel", nivel, 2'd2);
        chk("t4_medio_amb",   {A, M, B}, 3'b011);
        sa_raw = 1'b1;
        sm_raw = 1'b0;
        step(8);
        chk("t4_pre_erro", erro, 1'b0);
        step(1);
        chk("t4_erro",     erro, 1'b1);
        chk("t4_erro_amb", {A, M, B}, 3'b011);
        chk("t4_erro_nivel", nivel, 2'd2);
        chk("t4_erro_vld", nivel_valid, 1'b0);
        step(5);
        chk("t4_erro_hold", erro, 1'b1);
        sm_raw = 1'b1;
`ifdef ERRO_STICKY_EN
        step(15);
        chk("t4s_erro",  erro, 1'b1);
        chk("t4s_nivel", nivel, 2'd2);
        chk("t4s_amb",   {A, M, B}, 3'b011);
        do_reset();
        chk("t4s_rst_erro", erro, 1'b0);
`else
        step(9);
        chk("t4_exit_early", erro, 1'b1);
        chk("t4_exit_early_nivel", nivel, 2'd2);
        step(1);
        chk("t4_exit_erro",  erro, 1'b0);
        chk("t4_exit_nivel", nivel, 2'd3);
        chk("t4_exit_amb",   {A, M, B}, 3'b111);
        chk("t4_exit_vld",   nivel_valid, 1'b1);
        step(1);
        chk("t4_exit_vld_off", nivel_valid, 1'b0);
`endif

        // 5: all switches rise together -> direct jump VAZIO -> ALTO.
        do_reset();
        sa_raw = 1'b1;
        sm_raw = 1'b1;
        sb_raw = 1'b1;
        step(6);
        chk("t5_early_nivel", nivel, 2'd0);
        step(1);
        chk("t5_nivel", nivel, 2'd3);
        chk("t5_amb",   {A, M, B}, 3'b111);
        chk("t5_vld",   nivel_valid, 1'b1);
        chk("t5_erro",  erro, 1'b0);
        step(1);
        chk("t5_vld_off", nivel_valid, 1'b0);

        // 6: reset mid-debounce discards the partial count.
        do_reset();
        sb_raw = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("t6_rst_nivel", nivel, 2'd0);
        rst_n = 1'b1;
        step(6);
        chk("t6_early_nivel", nivel, 2'd0);
        step(1);
        chk("t6_nivel", nivel, 2'd1);
        chk("t6_vld",   nivel_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
